// File: rtl/tfo_check_arbiter_if.sv
// Handshake bundle between code-word requesters, the shared 2-of-5 checker and
// the downstream result consumer.
interface tfo_check_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [5*NUM_REQ-1:0] req_code;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic [4:0]           res_code;
    logic                 res_det;

    modport slave (
        input  req_valid, req_code, res_ready,
        output req_ready, res_valid, res_id, res_code, res_det
    );

    modport master (
        output req_valid, req_code, res_ready,
        input  req_ready, res_valid, res_id, res_code, res_det
    );
endinterface

// File: rtl/tfo_check_arbiter.sv
// Round-robin shared Two-out-of-Five checker with a one-deep registered result.
// Optional per-requester error counters are built when TFO_ERR_CNT_EN is defined.
module tfo_check_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    tfo_check_arbiter_if.slave       bus,
    input  logic                     i_cnt_clr,
    output logic [CNT_W*NUM_REQ-1:0] o_err_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    r_ptr;
    logic               r_res_vld_p1;
    logic [ID_W-1:0]    r_res_id_p1;
    logic [4:0]         r_res_code_p1;
    logic               r_res_det_p1;

    logic               w_out_free;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [4:0]         w_gnt_code;
    logic               w_gnt_det;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_req_ready;

    // (ptr + k) mod NUM_REQ without a divider; ptr < NUM_REQ and k < NUM_REQ
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] ptr, input int k);
        logic [ID_W:0] s;
        s = {1'b0, ptr} + (ID_W+1)'(k);
        if (s >= (ID_W+1)'(NUM_REQ))
            s = s - (ID_W+1)'(NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    function automatic logic f_tfo_det(input logic [4:0] code);
        logic [2:0] ones;
        ones = 3'd0;
        for (int b = 0; b < 5; b++)
            ones = ones + {2'b00, code[b]};
        return (ones != 3'd2);
    endfunction

    assign w_out_free = !r_res_vld_p1 || bus.res_ready;

    // Walk downward so the closest requester at or above the pointer wins last
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[f_wrap(r_ptr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_xfer = w_gnt_any && w_out_free && i_rst_n;

    always_comb begin
        w_gnt_code  = '0;
        w_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_gnt_idx)
                w_gnt_code = bus.req_code[5*i +: 5];
        end
        if (w_xfer)
            w_req_ready[w_gnt_idx] = 1'b1;
    end

    assign w_gnt_det = f_tfo_det(w_gnt_code);

    // ---- p0 -> p1: arbitration result into the held result register ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr         <= '0;
            r_res_vld_p1  <= 1'b0;
            r_res_id_p1   <= '0;
            r_res_code_p1 <= '0;
            r_res_det_p1  <= 1'b0;
        end else if (w_xfer) begin
            r_ptr         <= f_wrap(w_gnt_idx, 1);
            r_res_vld_p1  <= 1'b1;
            r_res_id_p1   <= w_gnt_idx;
            r_res_code_p1 <= w_gnt_code;
            r_res_det_p1  <= w_gnt_det;
        end else if (bus.res_ready) begin
            r_res_vld_p1  <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = r_res_vld_p1;
    assign bus.res_id    = r_res_id_p1;
    assign bus.res_code  = r_res_code_p1;
    assign bus.res_det   = r_res_det_p1;

`ifdef TFO_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt [NUM_REQ];

    // Clear has priority over a same-cycle increment; counts saturate
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!i_rst_n || i_cnt_clr)
                r_err_cnt[i] <= '0;
            else if (w_xfer && w_gnt_det && (w_gnt_idx == ID_W'(i)) && (r_err_cnt[i] != '1))
                r_err_cnt[i] <= r_err_cnt[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign o_err_cnt[CNT_W*g +: CNT_W] = r_err_cnt[g];
    end
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tfo_check_arbiter.sv
// Directed plus randomized bench for tfo_check_arbiter against a queue-free
// behavioural model of the round-robin 2-of-5 checker.
module tb_tfo_check_arbiter;
    localparam int N = 4;
`ifdef TFO_ERR_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cnt_clr;
    logic [CNT_W*N-1:0] err_cnt;

    tfo_check_arbiter_if #(.NUM_REQ(N)) bus ();

    tfo_check_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .i_cnt_clr (cnt_clr),
        .o_err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference state
    bit       m_vld;
    int       m_id;
    bit [4:0] m_code;
    bit       m_det;
    int       m_ptr;
    int       m_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_grant();
        if (!rst_n) return -1;
        if (m_vld && !bus.res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Check outputs for the current input cycle, then advance the model across the edge
    task automatic tick();
        int g;
        logic [CNT_W*N-1:0] exp_cnt;
        logic [N-1:0] exp_rdy;
        #1;
        g = pick_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_cnt = '0;
`ifdef TFO_ERR_CNT_EN
        for (int i = 0; i < N; i++) exp_cnt[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(bus.res_valid), 32'(m_vld));
        chk("res_id",    32'(bus.res_id),    32'(m_id));
        chk("res_code",  32'(bus.res_code),  32'(m_code));
        chk("res_det",   32'(bus.res_det),   32'(m_det));
        chk("err_cnt",   32'(err_cnt),       32'(exp_cnt));

        if (!rst_n) begin
            m_vld = 0; m_id = 0; m_code = 0; m_det = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (g >= 0) begin
                m_vld  = 1;
                m_id   = g;
                m_code = bus.req_code[5*g +: 5];
                m_det  = ($countones(m_code) != 2);
                m_ptr  = (g + 1) % N;
            end else if (bus.res_ready) begin
                m_vld = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (cnt_clr) m_cnt[i] = 0;
                else if (g == i && m_det && m_cnt[i] < CMAX) m_cnt[i]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    bit [4:0] codes [8] = '{5'b00000, 5'b00001, 5'b00111, 5'b11110,
                            5'b11111, 5'b10100, 5'b01001, 5'b11000};

    initial begin
        m_vld = 0; m_id = 0; m_code = 0; m_det = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        rst_n = 1'b0; cnt_clr = 1'b0;
        bus.req_valid = 4'b0001; bus.req_code = '0; bus.res_ready = 1'b1;
        @(negedge clk);
        tick(); tick();

        // single word, valid 2-of-5
        rst_n = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_code[4:0] = 5'b00011;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();

        // all requesters busy: full-throughput rotation
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) bus.req_code[5*i +: 5] = 5'($urandom);
            tick();
        end

        // code classification through requester 1
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            bus.req_code[9:5] = codes[c];
            tick();
        end

        // back-pressure hold, then resume
        bus.req_valid = 4'b0011;
        bus.req_code[4:0] = 5'b10001;
        bus.req_code[9:5] = 5'b11100;
        bus.res_ready = 1'b0;
        tick(); tick(); tick();
        bus.res_ready = 1'b1;
        tick(); tick(); tick();

        // requester 2 error words: saturation then clear-with-error
        bus.req_valid = 4'b0100;
        bus.req_code[14:10] = 5'b11111;
        for (int c = 0; c < 5; c++) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        bus.req_valid = 4'b0000;
        tick(); tick();

        // reset while a result is stalled
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        tick(); tick();

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) bus.req_code[5*i +: 5] = 5'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            cnt_clr       = ($urandom_range(0, 19) == 0);
            rst_n         = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
